mux_scan_ctrl: RTL
==================

// Module: mux_scan_ctrl
// PURPOSE
//  Upstream sequencer for the 4:1 select mux. Drives the mux select lines s1/s0
//  through the enabled channels. Waits a programmable settle time on each channel,
//  then samples the mux output y back.
//  Collects one bit per channel into a 4-bit snapshot. Publishes the snapshot once
//  per completed scan frame. Supports one-shot or continuous scanning.
// PARAMETERS
//  DWELL       4  settle cycles per channel before sampling (>=1)
//  CONTINUOUS  1  1: rescan until stop; 0: one frame per start
// PORTS
//  clk           in   1  single clock, rising edge
//  rst           in   1  asynchronous, active-high reset
//  start         in   1  begin scanning (accepted only in IDLE)
//  stop          in   1  request halt at end of current frame
//  ch_mask       in   4  channel enable, bit i = channel i (a,b,c,d)
//  y             in   1  mux output being scanned
//  s1, s0        out  1  mux select, {s1,s0} = current channel
//  busy          out  1  high whenever state != IDLE
//  sample_valid  out  1  1-cycle pulse: sample_bit/sample_ch valid
//  sample_ch     out  2  channel of last sample
//  sample_bit    out  1  sampled y value
//  frame_done    out  1  1-cycle pulse: snap updated
//  snap          out  4  last complete frame; disabled channels read 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, mask_q=0, stop_q=0, accumulator=0.
//  Reset mid-frame aborts immediately. No partial snapshot is published.
//  States: IDLE -> SETTLE -> SAMPLE -> (SETTLE | IDLE).
//  IDLE: start=1 with ch_mask!=0:
//   - latch mask_q=ch_mask;
//   - {s1,s0} = lowest enabled channel;
//   - clear accumulator and dwell counter;
//   - go to SETTLE.
//  IDLE: start=1 with ch_mask==0 is ignored.
//  start while busy is ignored. ch_mask changes mid-frame are ignored until the next start.
//  SETTLE: count DWELL cycles with select held stable, then go to SAMPLE.
//  SAMPLE: one cycle; y captured at its closing edge into accumulator[ch].
//   On the next cycle: sample_valid=1, sample_ch=ch, sample_bit=y.
//  Per-channel period = DWELL+1 cycles. Select changes only on the edge leaving SAMPLE.
//  Next channel: next higher enabled index in mask_q, wrapping 3->0.
//   Single enabled channel: the same channel is re-selected every frame.
//  Frame end: sample of the highest enabled channel.
//   - snap <= accumulator, with that bit merged in;
//   - frame_done pulses together with that sample_valid.
//  After frame end: if stop_q=1 or CONTINUOUS=0, go to IDLE and clear stop_q.
//   Otherwise start the next frame at the lowest enabled channel.
//  stop is latched into stop_q in any busy cycle. stop in IDLE is ignored.
//   Exception: start and stop asserted together in IDLE run exactly one frame.
//  Select on return to IDLE holds the last channel. busy drops on the same edge.
//  Latency, start to first sample_valid = DWELL+2 cycles.
//  Full frame with N enabled channels = N*(DWELL+1) cycles.
//  Dwell counter width = $clog2(DWELL+1). No overflow possible.
// CONFIGURATION
//  MUX_SCAN_DEGLITCH_EN defined:
//   - SAMPLE lasts 3 cycles; y sampled in each;
//   - stored bit = 2-of-3 majority;
//   - per-channel period = DWELL+3; first-sample latency = DWELL+4.
//  Undefined: single-cycle SAMPLE as above. No majority logic is synthesised.
// TESTING
//  Scenario A, basic frame: DWELL=4, mask=1111.
//   y driven as mux of a=1,b=0,c=1,d=1 per select.
//   Expected: selects 0,1,2,3; frame_done 20 cycles after start; snap=1101.
//  Scenario B, sparse mask: mask=0101.
//   Expected: only channels 0 and 2 selected; frame_done after 10 cycles; snap bits 1,3 = 0.
//  Scenario C, stop mid-frame: CONTINUOUS=1, stop pulsed during channel 1.
//   Expected: frame completes; frame_done pulses once; then busy=0.
//   Also: start with mask=0000 leaves busy=0.
//  Scenario D, async reset: rst asserted mid-SETTLE of channel 2.
//   Expected: s1=s0=0, busy=0, snap holds 0000, no frame_done.
//   Next start runs a clean frame.
//  Scenario E, MUX_SCAN_DEGLITCH_EN: y glitches low for 1 of the 3 sample cycles on channel 0 (a=1).
//   Expected: stored bit=1; frame period = 4*(DWELL+3) cycles.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Sequences the 4:1 mux select through enabled channels, samples y after a settle dwell, publishes a 4-bit snapshot per frame.
// Latency: first sample_valid DWELL+2 cycles after start; frame = N*(DWELL+1) cycles (DWELL+3 per channel with MUX_SCAN_DEGLITCH_EN).
// Backpressure: none; start is ignored while busy, stop takes effect at the end of the current frame.
module mux_scan_ctrl #(
    parameter int DWELL      = 4,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] ch_mask,
    input  logic       y,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       sample_valid,
    output logic [1:0] sample_ch,
    output logic       sample_bit,
    output logic       frame_done,
    output logic [3:0] snap
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam int         CW        = $clog2(DWELL + 1);

    logic [1:0]    state;
    logic [1:0]    ch;
    logic [3:0]    mask_q;
    logic          stop_q;
    logic [3:0]    acc;
    logic [3:0]    acc_merged;
    logic [CW-1:0] cnt;
    logic          sample_last;
    logic          bit_now;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    function automatic logic [1:0] highest_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i <= 3; i++)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    // Next higher enabled index, wrapping; returns c itself when it is the only one.
    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] c);
        logic [1:0] r;
        logic [1:0] idx;
        r = c;
        for (int k = 3; k >= 1; k--) begin
            idx = c + 2'(k);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

`ifdef MUX_SCAN_DEGLITCH_EN
    logic [1:0] sub_cnt;
    logic [1:0] votes;

    assign sample_last = (sub_cnt == 2'd2);
    assign bit_now     = (votes[0] & votes[1]) | (votes[0] & y) | (votes[1] & y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt <= 2'd0;
            votes   <= 2'd0;
        end else if (state == ST_SAMPLE) begin
            if (sample_last) begin
                sub_cnt <= 2'd0;
            end else begin
                votes[sub_cnt[0]] <= y;
                sub_cnt           <= sub_cnt + 2'd1;
            end
        end
    end
`else
    assign sample_last = 1'b1;
    assign bit_now     = y;
`endif

    assign {s1, s0} = ch;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        acc_merged     = acc;
        acc_merged[ch] = bit_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ch           <= 2'd0;
            mask_q       <= 4'd0;
            stop_q       <= 1'b0;
            acc          <= 4'd0;
            cnt          <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= 2'd0;
            sample_bit   <= 1'b0;
            frame_done   <= 1'b0;
            snap         <= 4'd0;
        end else begin
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && (ch_mask != 4'd0)) begin
                        mask_q <= ch_mask;
                        ch     <= lowest_ch(ch_mask);
                        acc    <= 4'd0;
                        cnt    <= '0;
                        stop_q <= stop;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (stop) stop_q <= 1'b1;
                    if (cnt == CW'(DWELL - 1)) begin
                        cnt   <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (stop) stop_q <= 1'b1;
                    if (sample_last) begin
                        sample_valid <= 1'b1;
                        sample_ch    <= ch;
                        sample_bit   <= bit_now;
                        if (ch == highest_ch(mask_q)) begin
                            snap       <= acc_merged;
                            frame_done <= 1'b1;
                            acc        <= 4'd0;
                            // A stop arriving in the final sample cycle still ends this frame.
                            if (stop_q || stop || !CONTINUOUS) begin
                                stop_q <= 1'b0;
                                state  <= ST_IDLE;
                            end else begin
                                ch    <= next_ch(mask_q, ch);
                                state <= ST_SETTLE;
                            end
                        end else begin
                            acc[ch] <= bit_now;
                            ch      <= next_ch(mask_q, ch);
                            state   <= ST_SETTLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
